// File: rtl/spi_master_24.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_24
//  Purpose  : Mode-0 (CPOL=0, CPHA=0) SPI master. One full-duplex transfer of
//             BIT_WIDTH bits per accepted tx_data_tick, MSB first. Returns the
//             received word with a one-cycle rx_data_tick.
//  Options  : define SPI_MASTER_CS_GAP_EN to hold ss_n high and busy asserted
//             for CS_GAP cycles after each transfer (MCP300x CS-high time).
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_24 #(
  parameter int BIT_WIDTH = 24,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_data_tick,
  input  logic [BIT_WIDTH-1:0] tx_data,
  output logic                 busy,
  output logic                 rx_data_tick,
  output logic [BIT_WIDTH-1:0] rx_data,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 ss_n
);

  // One counter serves both the SCLK half-period and the CS gap.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(BIT_WIDTH);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_WIDTH - 1);
`ifdef SPI_MASTER_CS_GAP_EN
  // DONE supplies the first high cycle after the transfer; GAP the rest.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 2);
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOW  = 3'd1,
    ST_HIGH = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     div_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [BIT_WIDTH-1:0] tx_shift_q;
  logic [BIT_WIDTH-1:0] rx_shift_q;
  logic [BIT_WIDTH-1:0] rx_data_q;
  logic                 rx_tick_q;
  logic                 busy_q;
  logic                 sclk_q;
  logic                 mosi_q;
  logic                 ss_n_q;

  logic [BIT_WIDTH-1:0] tx_shift_d;
  logic [BIT_WIDTH-1:0] rx_shift_d;
  logic                 div_last_d;
  logic                 start_d;

  // Shift-register next values, half-period terminal count and start qualifier.
  always_comb begin
    tx_shift_d = {tx_shift_q[BIT_WIDTH-2:0], 1'b0};
    rx_shift_d = {rx_shift_q[BIT_WIDTH-2:0], miso};
    div_last_d = (div_cnt_q == DIV_LAST);
`ifdef SPI_MASTER_CS_GAP_EN
    start_d    = tx_data_tick && (state_q == ST_IDLE);
`else
    // Without a gap, busy is already low in DONE, so a request seen there is
    // honoured; this yields exactly one ss_n-high cycle between transfers.
    start_d    = tx_data_tick && ((state_q == ST_IDLE) || (state_q == ST_DONE));
`endif
  end

  // Transfer state machine; every output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_tick_q  <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
    end else begin
      rx_tick_q <= 1'b0;
      if (start_d) begin
        tx_shift_q <= tx_data;
        rx_shift_q <= '0;
        bit_cnt_q  <= '0;
        div_cnt_q  <= '0;
        ss_n_q     <= 1'b0;
        sclk_q     <= 1'b0;
        mosi_q     <= tx_data[BIT_WIDTH-1];
        busy_q     <= 1'b1;
        state_q    <= ST_LOW;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_IDLE;
          end
          ST_LOW: begin
            if (div_last_d) begin
              // Rising SCLK edge: capture miso on the same clock edge.
              div_cnt_q  <= '0;
              sclk_q     <= 1'b1;
              rx_shift_q <= rx_shift_d;
              state_q    <= ST_HIGH;
            end else begin
              div_cnt_q <= div_cnt_q + 1'b1;
            end
          end
          ST_HIGH: begin
            if (div_last_d) begin
              div_cnt_q <= '0;
              sclk_q    <= 1'b0;
              if (bit_cnt_q == BIT_LAST) begin
                ss_n_q    <= 1'b1;
                mosi_q    <= 1'b0;
                rx_data_q <= rx_shift_q;
                rx_tick_q <= 1'b1;
`ifdef SPI_MASTER_CS_GAP_EN
                busy_q    <= 1'b1;
`else
                busy_q    <= 1'b0;
`endif
                state_q   <= ST_DONE;
              end else begin
                // Falling SCLK edge: present the next bit.
                tx_shift_q <= tx_shift_d;
                mosi_q     <= tx_shift_q[BIT_WIDTH-2];
                bit_cnt_q  <= bit_cnt_q + 1'b1;
                state_q    <= ST_LOW;
              end
            end else begin
              div_cnt_q <= div_cnt_q + 1'b1;
            end
          end
          ST_DONE: begin
`ifdef SPI_MASTER_CS_GAP_EN
            div_cnt_q <= '0;
            if (CS_GAP > 1) begin
              state_q <= ST_GAP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
`else
            state_q <= ST_IDLE;
`endif
          end
          ST_GAP: begin
`ifdef SPI_MASTER_CS_GAP_EN
            if (div_cnt_q == GAP_LAST) begin
              div_cnt_q <= '0;
              busy_q    <= 1'b0;
              state_q   <= ST_IDLE;
            end else begin
              div_cnt_q <= div_cnt_q + 1'b1;
            end
`else
            state_q <= ST_IDLE;
`endif
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign rx_data_tick = rx_tick_q;
  assign rx_data      = rx_data_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ss_n         = ss_n_q;

endmodule
`default_nettype wire
